// File: rtl/l2_ctrl_if.sv
// Bundle of control, fill and window-scan signals between l2_ctrl and its surroundings.
// slave is the controller side; master is the driver of start/clr/in_vld/win_rdy.
interface l2_ctrl_if #(
    parameter int unsigned AW = 7
) ();
    logic          start;
    logic          clr;
    logic          in_vld;
    logic          in_rdy;
    logic          wr;
    logic [AW-1:0] addr_wr;
    logic          rd;
    logic [AW-1:0] addr_rd;
    logic          win_vld;
    logic          win_rdy;
    logic [3:0]    win_row;
    logic [3:0]    win_col;
    logic          busy;
    logic          done;

    modport master (
        output start, clr, in_vld, win_rdy,
        input  in_rdy, wr, addr_wr, rd, addr_rd, win_vld, win_row, win_col, busy, done
    );

    modport slave (
        input  start, clr, in_vld, win_rdy,
        output in_rdy, wr, addr_wr, rd, addr_rd, win_vld, win_row, win_col, busy, done
    );
endinterface

// File: rtl/l2_ctrl.sv
// Fills a MAP_W x MAP_H sample buffer, then scans it with a 2x2 window.
// A window is named by its bottom-right tap; the other taps are at -1, -MAP_W and -MAP_W-1.
module l2_ctrl #(
    parameter int unsigned MAP_W  = 11,
    parameter int unsigned MAP_H  = 11,
    parameter int unsigned STRIDE = 1,
    parameter int unsigned AW     = 7
) (
    input  logic     clk,
    input  logic     rst_n,
    l2_ctrl_if.slave bus
);
    localparam logic [AW-1:0] LastWrAddr  = AW'(MAP_W * MAP_H - 1);
    localparam logic [AW-1:0] FirstAnchor = AW'(MAP_W + 1);
    localparam int unsigned   RowLastI    = 1 + ((MAP_H - 2) / STRIDE) * STRIDE;
    localparam int unsigned   ColLastI    = 1 + ((MAP_W - 2) / STRIDE) * STRIDE;
    localparam logic [3:0]    RowLast     = 4'(RowLastI);
    localparam logic [3:0]    ColLast     = 4'(ColLastI);
    localparam logic [4:0]    ColMax      = 5'(MAP_W - 1);

    typedef enum logic [1:0] {StIdle, StFill, StScan} state_e;

    state_e        r_state;
    logic          r_in_rdy;
    logic          r_win_vld;
    logic          r_busy;
    logic          r_done;
    logic [AW-1:0] r_wcnt;
    logic [AW-1:0] r_addr_rd;
    logic [3:0]    r_row;
    logic [3:0]    r_col;

    logic [4:0]    w_col_sum;
    logic          w_col_wrap;
    logic [3:0]    w_col_nxt;
    logic [3:0]    w_row_nxt;
    logic [AW-1:0] w_addr_nxt;
    logic          w_last_win;

    always_comb begin
        w_col_sum  = {1'b0, r_col} + 5'(STRIDE);
        w_col_wrap = (w_col_sum > ColMax);
        w_col_nxt  = w_col_wrap ? 4'd1 : w_col_sum[3:0];
        w_row_nxt  = w_col_wrap ? (r_row + 4'(STRIDE)) : r_row;
        w_addr_nxt = AW'(32'(w_row_nxt) * MAP_W + 32'(w_col_nxt));
        w_last_win = (r_row == RowLast) && (r_col == ColLast);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_in_rdy  <= 1'b0;
            r_win_vld <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wcnt    <= '0;
            r_addr_rd <= '0;
            r_row     <= '0;
            r_col     <= '0;
        end else begin
            r_done <= 1'b0;
            // clr overrides start and both handshakes
            if (bus.clr) begin
                r_state   <= StIdle;
                r_in_rdy  <= 1'b0;
                r_win_vld <= 1'b0;
                r_busy    <= 1'b0;
                r_wcnt    <= '0;
                r_addr_rd <= '0;
                r_row     <= '0;
                r_col     <= '0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (bus.start) begin
                            r_state  <= StFill;
                            r_in_rdy <= 1'b1;
                            r_busy   <= 1'b1;
                            r_wcnt   <= '0;
                        end
                    end
                    StFill: begin
                        if (bus.in_vld) begin
                            if (r_wcnt == LastWrAddr) begin
                                r_state   <= StScan;
                                r_in_rdy  <= 1'b0;
                                r_win_vld <= 1'b1;
                                r_wcnt    <= '0;
                                r_row     <= 4'd1;
                                r_col     <= 4'd1;
                                r_addr_rd <= FirstAnchor;
                            end else begin
                                r_wcnt <= r_wcnt + 1'b1;
                            end
                        end
                    end
                    StScan: begin
                        if (bus.win_rdy) begin
                            if (w_last_win) begin
                                r_state   <= StIdle;
                                r_win_vld <= 1'b0;
                                r_busy    <= 1'b0;
                                r_done    <= 1'b1;
                                r_row     <= '0;
                                r_col     <= '0;
                                r_addr_rd <= '0;
                            end else begin
                                r_row     <= w_row_nxt;
                                r_col     <= w_col_nxt;
                                r_addr_rd <= w_addr_nxt;
                            end
                        end
                    end
                    default: begin
                        r_state   <= StIdle;
                        r_in_rdy  <= 1'b0;
                        r_win_vld <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.in_rdy  = r_in_rdy;
    assign bus.wr      = bus.in_vld & r_in_rdy;
    assign bus.addr_wr = r_wcnt;
    assign bus.rd      = r_win_vld;
    assign bus.win_vld = r_win_vld;
    assign bus.addr_rd = r_addr_rd;
    assign bus.win_row = r_row;
    assign bus.win_col = r_col;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_l2_ctrl.sv
// Bench for l2_ctrl: STRIDE=1 and STRIDE=2 instances share one stimulus stream and are
// each compared every cycle against a pass-level model built from a list of window anchors.
module tb_l2_ctrl;
    localparam int unsigned MapW   = 11;
    localparam int unsigned MapH   = 11;
    localparam int unsigned Aw     = 7;
    localparam int          NumCyc = 5000;
    localparam int          NF     = 10;

    logic clk;
    logic rst_n;

    l2_ctrl_if #(.AW(Aw)) if1 ();
    l2_ctrl_if #(.AW(Aw)) if2 ();

    l2_ctrl #(.MAP_W(MapW), .MAP_H(MapH), .STRIDE(1), .AW(Aw)) u_dut_s1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    l2_ctrl #(.MAP_W(MapW), .MAP_H(MapH), .STRIDE(2), .AW(Aw)) u_dut_s2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2)
    );

    bit d_start, d_clr, d_vld, d_wrdy;

    assign if1.start   = d_start;
    assign if1.clr     = d_clr;
    assign if1.in_vld  = d_vld;
    assign if1.win_rdy = d_wrdy;
    assign if2.start   = d_start;
    assign if2.clr     = d_clr;
    assign if2.in_vld  = d_vld;
    assign if2.win_rdy = d_wrdy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: mode 0 idle, 1 fill, 2 scan; wi indexes the anchor list.
    int    anc [2][$];
    int    m_mode [2];
    int    m_wc [2];
    int    m_wi [2];
    bit    m_done [2];
    int    got [2][NF];
    int    want [2][NF];
    bit    chk_en [2][NF];
    string fname [NF];
    int    n_cmp;
    int    n_mis;
    bit    rst_hit;

    task automatic check(input string tag, input int obs_v, input int exp_v);
        n_cmp++;
        if (obs_v !== exp_v) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs_v, exp_v, $time);
        end
    endtask

    task automatic sample();
        got[0] = '{int'(if1.in_rdy), int'(if1.wr), int'(if1.addr_wr), int'(if1.rd),
                   int'(if1.addr_rd), int'(if1.win_vld), int'(if1.win_row),
                   int'(if1.win_col), int'(if1.busy), int'(if1.done)};
        got[1] = '{int'(if2.in_rdy), int'(if2.wr), int'(if2.addr_wr), int'(if2.rd),
                   int'(if2.addr_rd), int'(if2.win_vld), int'(if2.win_row),
                   int'(if2.win_col), int'(if2.busy), int'(if2.done)};
    endtask

    task automatic model_expect(input int k, input bit all_fields);
        int a;
        a = (m_mode[k] == 2) ? anc[k][m_wi[k]] : 0;
        want[k][0] = int'(m_mode[k] == 1);
        want[k][1] = int'(m_mode[k] == 1 && d_vld);
        want[k][2] = (m_mode[k] == 1) ? m_wc[k] : 0;
        want[k][3] = int'(m_mode[k] == 2);
        want[k][4] = a;
        want[k][5] = int'(m_mode[k] == 2);
        want[k][6] = a / int'(MapW);
        want[k][7] = a % int'(MapW);
        want[k][8] = int'(m_mode[k] != 0);
        want[k][9] = int'(m_done[k]);
        for (int f = 0; f < NF; f++) chk_en[k][f] = 1'b1;
        if (!all_fields && m_mode[k] != 2) begin
            chk_en[k][4] = 1'b0;
            chk_en[k][6] = 1'b0;
            chk_en[k][7] = 1'b0;
        end
    endtask

    task automatic check_all(input string pfx, input bit all_fields);
        sample();
        for (int k = 0; k < 2; k++) begin
            model_expect(k, all_fields);
            for (int f = 0; f < NF; f++) begin
                if (chk_en[k][f])
                    check($sformatf("%s_s%0d_%s", pfx, k + 1, fname[f]), got[k][f], want[k][f]);
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0;
            m_wc[k]   = 0;
            m_wi[k]   = 0;
            m_done[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            m_done[k] = 1'b0;
            if (d_clr) begin
                m_mode[k] = 0;
                m_wc[k]   = 0;
                m_wi[k]   = 0;
            end else begin
                case (m_mode[k])
                    0: if (d_start) begin
                        m_mode[k] = 1;
                        m_wc[k]   = 0;
                    end
                    1: if (d_vld) begin
                        if (m_wc[k] == int'(MapW * MapH) - 1) begin
                            m_mode[k] = 2;
                            m_wc[k]   = 0;
                            m_wi[k]   = 0;
                        end else begin
                            m_wc[k]++;
                        end
                    end
                    default: if (d_wrdy) begin
                        if (m_wi[k] == anc[k].size() - 1) begin
                            m_mode[k] = 0;
                            m_done[k] = 1'b1;
                        end else begin
                            m_wi[k]++;
                        end
                    end
                endcase
            end
        end
    endtask

    task automatic drive(input int c);
        if (c < 300) begin
            d_start = (c == 0) || (c > 150 && c < 220 && (c % 7) == 0);
            d_clr   = 1'b0;
            d_vld   = 1'b1;
            d_wrdy  = 1'b1;
        end else if (c < 600) begin
            d_start = (c == 300) || (c == 370) || (c == 500);
            d_clr   = (c == 361) || (c == 540);
            d_vld   = 1'b1;
            d_wrdy  = 1'b1;
        end else begin
            d_start = ($urandom_range(0, 9) == 0);
            d_clr   = ($urandom_range(0, 599) == 0);
            d_vld   = ($urandom_range(0, 3) != 0);
            d_wrdy  = ($urandom_range(0, 9) < 6);
        end
    endtask

    initial begin
        int strd;
        fname = '{"in_rdy", "wr", "addr_wr", "rd", "addr_rd", "win_vld", "win_row",
                  "win_col", "busy", "done"};
        for (int k = 0; k < 2; k++) begin
            strd = k + 1;
            for (int r = 1; r <= int'(MapH) - 1; r += strd)
                for (int cc = 1; cc <= int'(MapW) - 1; cc += strd)
                    anc[k].push_back(r * int'(MapW) + cc);
        end
        n_cmp   = 0;
        n_mis   = 0;
        rst_hit = 1'b0;
        d_start = 1'b0;
        d_clr   = 1'b0;
        d_vld   = 1'b0;
        d_wrdy  = 1'b0;
        rst_n   = 1'b0;
        model_reset();
        check("anchor_count_s1", anc[0].size(), 100);
        check("anchor_count_s2", anc[1].size(), 25);
        #3;
        check_all("por", 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < NumCyc; c++) begin
            @(negedge clk);
            drive(c);
            #1;
            check_all("cyc", 1'b0);
            if (c >= 2000 && !rst_hit && m_mode[0] == 2) begin
                rst_hit = 1'b1;
                d_start = 1'b0;
                d_clr   = 1'b0;
                d_vld   = 1'b0;
                d_wrdy  = 1'b0;
                #1 rst_n = 1'b0;
                #1;
                model_reset();
                check_all("async_rst", 1'b1);
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(posedge clk);
                model_step();
            end
        end
        check("rst_mid_scan_seen", int'(rst_hit), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/l2_ctrl.md
L2_CTRL -- requirements
Module: l2_ctrl

Interface
REQ-001 Parameter MAP_W, default 11: feature-map width in samples.
REQ-002 Parameter MAP_H, default 11: feature-map height in samples.
REQ-003 Parameter STRIDE, default 1: 2x2 window step; legal values 1 or 2 only.
REQ-004 Parameter AW, default 7: buffer address width; MAP_W*MAP_H SHALL be at most 2^AW.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle request to begin a fill-and-scan pass.
REQ-008 clr  input  1  synchronous abort to IDLE.
REQ-009 in_vld  input  1  upstream sample valid; data goes straight to buffer din.
REQ-010 in_rdy  output  1  controller accepts a sample this cycle.
REQ-011 wr  output  1  buffer write enable.
REQ-012 addr_wr  output  AW  buffer write address.
REQ-013 rd  output  1  buffer read strobe, equal to win_vld.
REQ-014 addr_rd  output  AW  window anchor address (bottom-right tap of the 2x2 window).
REQ-015 win_vld  output  1  the 4-tap window on the buffer outputs is valid.
REQ-016 win_rdy  input  1  downstream accepts the current window.
REQ-017 win_row  output  4  row index of the anchor tap.
REQ-018 win_col  output  4  column index of the anchor tap.
REQ-019 busy  output  1  high in FILL or SCAN.
REQ-020 done  output  1  one-cycle pulse after the last window is accepted.

Function
REQ-021 FSM states: IDLE, FILL, SCAN; the state is encoded in registers.
REQ-022 IDLE->FILL: on start=1 and clr=0; start in FILL or SCAN SHALL be ignored.
REQ-023 FILL: in_rdy=1; wr = in_vld & in_rdy (combinational); addr_wr = write counter, starting at 0 and incremented by 1 on each write.
REQ-024 FILL->SCAN: on the cycle the write at addr_wr = MAP_W*MAP_H-1 occurs; the write counter returns to 0.
REQ-025 SCAN: win_vld=1 from the first SCAN cycle; the first anchor is row 1, col 1 (addr_rd = MAP_W+1); the buffer taps are addr_rd-MAP_W-1, addr_rd-MAP_W, addr_rd-1 and addr_rd.
REQ-026 addr_rd, win_row and win_col are registered and SHALL hold stable while win_vld=1 and win_rdy=0.
REQ-027 On win_vld & win_rdy: col += STRIDE; if the new col > MAP_W-1, col = 1 and row += STRIDE; addr_rd = row*MAP_W+col, updated in the same edge.
REQ-028 Last window: row and col both at the largest value of 1+k*STRIDE that is <= MAP_H-1 and <= MAP_W-1 respectively (defaults: STRIDE=1 gives 120 and 100 windows; STRIDE=2 gives 108 and 25 windows).
REQ-029 Acceptance of the last window: the next state is IDLE, done=1 for exactly that next cycle, and win_vld=0.
REQ-030 Window throughput: one window per cycle while win_rdy is held high; no bubble between windows.
REQ-031 Fill throughput: one sample per cycle while in_vld is held high; in_vld gaps SHALL stall the counter without a write.
REQ-032 Outside FILL: in_rdy=0 and wr=0; outside SCAN: win_vld=0 and rd=0.
REQ-033 clr=1 in any state: next state IDLE, all counters 0, no done pulse; clr takes priority over start and over the handshakes in the same cycle.
REQ-034 busy = (state != IDLE).

Reset
REQ-035 rst_n=0: immediately, with no clock, state=IDLE; in_rdy, wr, rd, win_vld, done and busy = 0; addr_wr, addr_rd, win_row and win_col = 0.
REQ-036 Reset asserted mid-FILL or mid-SCAN SHALL abandon the pass; after release, the block waits for a new start.

Verification
REQ-037 Default parameters, start then 121 back-to-back in_vld -> addr_wr runs 0..120; the cycle after the write to 120, win_vld=1 with addr_rd=12, win_row=1 and win_col=1.
REQ-038 SCAN with win_rdy held at 1 -> addr_rd sequence 12..21, 23..32, ..., 111..120 (100 windows); done pulses once, in the cycle after addr_rd 120 is accepted; busy=0 in that same cycle.
REQ-039 STRIDE=2 -> anchors 12, 14, ..., 20, 34, ..., 108 (25 windows); done after 108.
REQ-040 win_rdy toggling 0/1 in SCAN -> addr_rd stable during the 0 cycles; no window is skipped or repeated; in_vld with gaps during FILL -> no wr in the gap cycles.
REQ-041 clr at the write to addr_wr 60 and again mid-SCAN -> IDLE on the next cycle with no done; a following start performs a full correct pass.
REQ-042 rst_n pulsed low asynchronously mid-SCAN -> outputs reach their reset values before the next clock edge; start asserted during SCAN -> ignored.
